// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, packet-atomic sharing of one UART transmit port.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter int         ID_W        = 2,
   parameter int         HEADER_EN   = 1,
   parameter logic [7:0] HEADER_BASE = 8'hA0,
   parameter int         MAX_LEN     = 64
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_byte,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 trunc
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_header = 2'd1;
   localparam logic [1:0] c_st_data   = 2'd2;

   localparam logic [1:0]      c_st_after_arb = (HEADER_EN != 0) ? c_st_header : c_st_data;
   localparam logic [7:0]      c_cnt_final    = 8'(MAX_LEN - 1);
   localparam logic [ID_W-1:0] c_last_init    = ID_W'(NUM_REQ - 1);

   logic [1:0]      state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [7:0]      byte_cnt_q, byte_cnt_d;
   logic            trunc_q, trunc_d;

   logic               sel_valid;
   logic               sel_last;
   logic [7:0]         sel_data;
   logic [NUM_REQ-1:0] sel_onehot;

   logic               arb_hi_found;
   logic               arb_lo_found;
   logic [ID_W-1:0]    arb_hi_idx;
   logic [ID_W-1:0]    arb_lo_idx;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;

   // Signals of the currently granted requester
   always_comb begin
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      sel_data   = 8'h00;
      sel_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            sel_valid     = req_valid[i];
            sel_last      = req_last[i];
            sel_data      = req_data[8*i +: 8];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Rotating priority: lowest index above last_grant wins, otherwise the
   // lowest index at or below it (last_grant itself is searched last).
   always_comb begin
      arb_hi_found = 1'b0;
      arb_lo_found = 1'b0;
      arb_hi_idx   = '0;
      arb_lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (ID_W'(i) > last_grant_q) begin
               arb_hi_found = 1'b1;
               arb_hi_idx   = ID_W'(i);
            end else begin
               arb_lo_found = 1'b1;
               arb_lo_idx   = ID_W'(i);
            end
         end
      end
      arb_any = arb_hi_found | arb_lo_found;
      arb_idx = arb_hi_found ? arb_hi_idx : arb_lo_idx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= c_st_idle;
         grant_id_q   <= '0;
         last_grant_q <= c_last_init;
         byte_cnt_q   <= 8'h00;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         byte_cnt_q   <= byte_cnt_d;
         trunc_q      <= trunc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      byte_cnt_d   = byte_cnt_q;
      trunc_d      = 1'b0;
      case (state_q)
         c_st_idle: begin
            if (arb_any) begin
               grant_id_d = arb_idx;
               byte_cnt_d = 8'h00;
               state_d    = c_st_after_arb;
            end
         end
         c_st_header: begin
            if (tx_ready) begin
               state_d = c_st_data;
            end
         end
         c_st_data: begin
            if (sel_valid && tx_ready) begin
               byte_cnt_d = byte_cnt_q + 8'd1;
               // An explicit last on the final allowed byte is a normal end.
               if (sel_last) begin
                  state_d      = c_st_idle;
                  last_grant_d = grant_id_q;
               end else if (byte_cnt_q == c_cnt_final) begin
                  state_d      = c_st_idle;
                  last_grant_d = grant_id_q;
                  trunc_d      = 1'b1;
               end
            end
         end
         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_byte   = 8'h00;
      req_ready = '0;
      case (state_q)
         c_st_header: begin
            tx_valid = 1'b1;
            tx_byte  = HEADER_BASE | 8'(grant_id_q);
         end
         c_st_data: begin
            tx_valid  = sel_valid;
            tx_byte   = sel_data;
            req_ready = sel_onehot & {NUM_REQ{tx_ready}};
         end
         default: begin
            tx_valid  = 1'b0;
            tx_byte   = 8'h00;
            req_ready = '0;
         end
      endcase
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q != c_st_idle);
   assign trunc    = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed and randomized checks of uart_tx_arbiter against a
//            packet-level reference model. Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic        tx_ready  = 1'b0;

   logic [3:0] rr_a, rr_b;
   logic [7:0] tb_a, tb_b;
   logic       tv_a, tv_b;
   logic [1:0] gid_a, gid_b;
   logic       busy_a, busy_b, trunc_a, trunc_b;

   uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .HEADER_EN(1), .HEADER_BASE(8'hA0), .MAX_LEN(3)) u_dut_hdr (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(rr_a), .tx_byte(tb_a), .tx_valid(tv_a),
      .tx_ready(tx_ready), .grant_id(gid_a), .busy(busy_a), .trunc(trunc_a));

   uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .HEADER_EN(0), .HEADER_BASE(8'hA0), .MAX_LEN(4)) u_dut_nohdr (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(rr_b), .tx_byte(tb_b), .tx_valid(tv_b),
      .tx_ready(tx_ready), .grant_id(gid_b), .busy(busy_b), .trunc(trunc_b));

   initial forever #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: one entry per DUT instance, owner = -1 when idle
   int m_hdr_en [2] = '{1, 0};
   int m_max    [2] = '{3, 4};
   int m_owner  [2];
   int m_last   [2];
   int m_sent   [2];
   int m_gid    [2];
   bit m_hdr    [2];
   bit m_trunc  [2];

   logic [8:0] rq [4][$];
   logic [3:0] en_mask = 4'hF;
   int         drv_sel = 0;

   logic [7:0] stream_a[$], stream_b[$];
   int         xcyc_a[$];
   logic       busy_log[$], tvb_log[$];
   int         rr_pulse[4];
   int         bad_rr, unstable, trunc_cnt, trunc_cyc;
   logic       prev_pend;
   logic [7:0] prev_tb;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_owner[m] = -1;
         m_last[m]  = 3;
         m_sent[m]  = 0;
         m_gid[m]   = 0;
         m_hdr[m]   = 1'b0;
         m_trunc[m] = 1'b0;
      end
   endfunction

   function automatic logic [16:0] model_vec(input int m);
      logic       e_tv;
      logic [7:0] e_tb;
      logic [3:0] e_rr;
      logic       e_busy;
      int         o;
      e_tv = 1'b0; e_tb = 8'h00; e_rr = 4'h0; e_busy = 1'b0;
      o = m_owner[m];
      if (o >= 0) begin
         e_busy = 1'b1;
         if (m_hdr[m]) begin
            e_tv = 1'b1;
            e_tb = 8'hA0 + 8'(o);
         end else begin
            e_tv = req_valid[o];
            e_tb = req_data[8*o +: 8];
            e_rr = tx_ready ? 4'(1 << o) : 4'h0;
         end
      end
      return {e_tv, e_tv ? e_tb : 8'h00, e_rr, e_busy, 2'(m_gid[m]), m_trunc[m]};
   endfunction

   function automatic void model_advance(input int m);
      int c;
      int o;
      if (!reset_n) return;
      m_trunc[m] = 1'b0;
      o = m_owner[m];
      if (o < 0) begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_last[m] + k) % 4;
            if (m_owner[m] < 0 && req_valid[c[1:0]]) begin
               m_owner[m] = c;
               m_gid[m]   = c;
               m_hdr[m]   = (m_hdr_en[m] != 0);
               m_sent[m]  = 0;
            end
         end
      end else if (m_hdr[m]) begin
         if (tx_ready) m_hdr[m] = 1'b0;
      end else if (req_valid[o] && tx_ready) begin
         m_sent[m]++;
         if (req_last[o]) begin
            m_last[m]  = o;
            m_owner[m] = -1;
         end else if (m_sent[m] == m_max[m]) begin
            m_last[m]  = o;
            m_owner[m] = -1;
            m_trunc[m] = 1'b1;
         end
      end
   endfunction

   task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
      logic [16:0] ev, ov;
      @(negedge clock);
      req_valid = v; req_data = d; req_last = l; tx_ready = r;
      #1;
      for (int m = 0; m < 2; m++) begin
         ev = model_vec(m);
         if (m == 0) ov = {tv_a, ev[16] ? tb_a : 8'h00, rr_a, busy_a, gid_a, trunc_a};
         else        ov = {tv_b, ev[16] ? tb_b : 8'h00, rr_b, busy_b, gid_b, trunc_b};
         check_val($sformatf("cyc%0d_u%0d", cyc, m), 32'(ov), 32'(ev));
      end
      busy_log.push_back(busy_a);
      tvb_log.push_back(tv_b);
      if (tv_a && tx_ready) begin
         stream_a.push_back(tb_a);
         xcyc_a.push_back(cyc);
      end
      if (tv_b && tx_ready) stream_b.push_back(tb_b);
      for (int i = 0; i < 4; i++) rr_pulse[i] += int'(rr_a[i]);
      if (rr_a != 4'h0 && (rr_a != (4'b0001 << gid_a) || !tx_ready)) bad_rr++;
      if (prev_pend && (!tv_a || tb_a != prev_tb)) unstable++;
      prev_pend = tv_a && !tx_ready;
      prev_tb   = tb_a;
      if (trunc_a) begin
         trunc_cnt++;
         if (trunc_cyc < 0) trunc_cyc = cyc;
      end
      model_advance(0);
      model_advance(1);
      cyc++;
   endtask

   task automatic run(input int ncyc, input int rmode);
      logic [3:0]  v, l, rdy;
      logic [31:0] d;
      logic        r;
      for (int c = 0; c < ncyc; c++) begin
         v = '0; l = '0; d = '0;
         for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0 && en_mask[i]) begin
               v[i]         = 1'b1;
               d[8*i +: 8]  = rq[i][0][7:0];
               l[i]         = rq[i][0][8];
            end
         end
         r = (rmode == 0) ? 1'b1 : (c % 4 == 0);
         step(v, d, l, r);
         rdy = (drv_sel == 0) ? rr_a : rr_b;
         for (int i = 0; i < 4; i++) begin
            if (rdy[i] && v[i]) void'(rq[i].pop_front());
         end
      end
   endtask

   task automatic clear_mon();
      stream_a.delete(); stream_b.delete(); xcyc_a.delete();
      for (int i = 0; i < 4; i++) begin
         rr_pulse[i] = 0;
         rq[i].delete();
      end
      bad_rr = 0; unstable = 0; trunc_cnt = 0; trunc_cyc = -1; prev_pend = 1'b0;
      en_mask = 4'hF;
   endtask

   // Asynchronous assertion mid-cycle, release on a falling edge with no requests
   task automatic reset_async();
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst_u0", 32'({tv_a, tb_a, rr_a, busy_a, gid_a, trunc_a}), 32'h0);
      check_val("rst_u1", 32'({tv_b, tb_b, rr_b, busy_b, gid_b, trunc_b}), 32'h0);
      model_reset();
      prev_pend = 1'b0;
      repeat (2) @(negedge clock);
      @(negedge clock);
      req_valid = '0;
      reset_n   = 1'b1;
   endtask

   task automatic check_stream(input string tag, input int which, input logic [7:0] exp[$]);
      logic [7:0] got[$];
      if (which == 0) got = stream_a;
      else            got = stream_b;
      check_val({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[i]) begin
         check_val($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(exp[i]));
      end
   endtask

   initial begin
      logic [7:0] exp[$];
      int         t0, k, stall_bad;

      model_reset();
      clear_mon();
      #1;
      check_val("rst0", 32'({tv_a, tb_a, rr_a, busy_a, gid_a, trunc_a}), 32'h0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // Single packet from requester 2
      rq[2].push_back(9'h011); rq[2].push_back(9'h122);
      run(8, 0);
      exp = '{8'hA2, 8'h11, 8'h22};
      check_stream("single", 0, exp);
      check_val("rdy2_pulses", 32'(rr_pulse[2]), 32'd2);
      if (xcyc_a.size() >= 3) begin
         check_val("busy_at_last", 32'(busy_log[xcyc_a[2]]), 32'd1);
         check_val("busy_after", 32'(busy_log[xcyc_a[2] + 1]), 32'd0);
      end else begin
         check_val("busy_after_missing", 32'(xcyc_a.size()), 32'd3);
      end

      // Round robin with every requester permanently valid
      reset_async();
      clear_mon();
      for (int i = 0; i < 4; i++)
         for (int p = 0; p < 3; p++) rq[i].push_back(9'h130 + 9'(i));
      run(20, 0);
      exp = '{8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32, 8'hA3, 8'h33, 8'hA0, 8'h30};
      while (stream_a.size() > exp.size()) void'(stream_a.pop_back());
      check_stream("rr", 0, exp);
      check_val("rr_bad_ready", 32'(bad_rr), 32'd0);

      // Backpressure with a 1,0,0,0 ready pattern
      reset_async();
      clear_mon();
      rq[1].push_back(9'h061); rq[1].push_back(9'h162);
      rq[3].push_back(9'h171);
      run(40, 1);
      exp = '{8'hA1, 8'h61, 8'h62, 8'hA3, 8'h71};
      check_stream("bp", 0, exp);
      check_val("bp_unstable", 32'(unstable), 32'd0);
      check_val("bp_bad_ready", 32'(bad_rr), 32'd0);

      // Truncation at MAX_LEN=3, then a last on the third byte ends normally
      reset_async();
      clear_mon();
      rq[1].push_back(9'h040); rq[1].push_back(9'h041); rq[1].push_back(9'h042);
      rq[1].push_back(9'h043); rq[1].push_back(9'h044); rq[1].push_back(9'h145);
      rq[2].push_back(9'h150);
      run(30, 0);
      exp = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'hA2, 8'h50, 8'hA1, 8'h43, 8'h44, 8'h45};
      check_stream("trunc", 0, exp);
      check_val("trunc_count", 32'(trunc_cnt), 32'd1);
      check_val("trunc_when", 32'(trunc_cyc), (xcyc_a.size() > 3) ? 32'(xcyc_a[3] + 1) : 32'hFFFF);

      // Stall of the granted requester, then reset mid-packet
      reset_async();
      clear_mon();
      rq[1].push_back(9'h111);
      rq[2].push_back(9'h021); rq[2].push_back(9'h022); rq[2].push_back(9'h123);
      run(6, 0);
      rq[0].push_back(9'h101); rq[3].push_back(9'h131);
      en_mask   = 4'b1011;
      stall_bad = 0;
      for (int s = 0; s < 10; s++) begin
         run(1, 0);
         if (tv_a !== 1'b0 || gid_a !== 2'd2 || busy_a !== 1'b1) stall_bad++;
      end
      check_val("stall_hold", 32'(stall_bad), 32'd0);
      check_val("stall_len", 32'(stream_a.size()), 32'd4);
      reset_async();
      clear_mon();
      for (int i = 0; i < 4; i++) rq[i].push_back(9'h180 + 9'(i));
      run(3, 0);
      exp = '{8'hA0, 8'h80};
      check_stream("post_rst", 0, exp);

      // No header: payload only, one cycle of arbitration latency
      reset_async();
      clear_mon();
      rq[3].push_back(9'h155);
      drv_sel = 1;
      t0 = cyc;
      run(4, 0);
      drv_sel = 0;
      exp = '{8'h55};
      check_stream("nohdr", 1, exp);
      k = t0;
      while (k < tvb_log.size() && tvb_log[k] !== 1'b1) k++;
      check_val("nohdr_latency", 32'(k - t0), 32'd1);

      // Randomized traffic checked cycle by cycle against the model
      reset_async();
      clear_mon();
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) reset_async();
         step(4'($urandom) | 4'($urandom), $urandom, 4'($urandom & $urandom),
              ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
